// File: rtl/uart_tx_arbiter.sv
// Packet-level arbiter sharing one uart_tx_buf between two byte-stream requesters.
// Round-robin on contention, credit-paced puts, optional stall timeout that releases the grant.
module uart_tx_arbiter #(
  parameter int TX_DEPTH = 16,
  parameter int HOLD_MAX = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       tx_put,
  output logic [7:0] tx_data,
  input  logic       tx_empty,
  output logic [1:0] grant,
  output logic       abort
);

  localparam int CW = $clog2(TX_DEPTH) + 1;
  localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] CRED_FULL = CW'(TX_DEPTH);
  localparam logic [HW-1:0] HOLD_LIM  = HW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, DRAIN} state_e;

  state_e        state_q, state_d;
  logic          port_q, port_d;
  logic          last_grant_q, last_grant_d;
  logic [CW-1:0] credits_q, credits_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          drain_first_q, drain_first_d;
  logic          tx_put_q, tx_put_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          abort_q, abort_d;
  logic [1:0]    grant_q, grant_d;

  logic          sel_valid, sel_last, xfer, pick;
  logic [7:0]    sel_data;

  assign req0_ready = (state_q == GRANT0) && (credits_q != '0);
  assign req1_ready = (state_q == GRANT1) && (credits_q != '0);

  assign sel_valid = port_q ? req1_valid : req0_valid;
  assign sel_last  = port_q ? req1_last  : req0_last;
  assign sel_data  = port_q ? req1_data  : req0_data;
  assign xfer      = sel_valid && (req0_ready || req1_ready);
  // With both valid, the port that did not finish last wins.
  assign pick      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    port_d        = port_q;
    last_grant_d  = last_grant_q;
    credits_d     = credits_q;
    hold_cnt_d    = hold_cnt_q;
    drain_first_d = drain_first_q;
    tx_put_d      = 1'b0;
    tx_data_d     = tx_data_q;
    abort_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tx_empty && !tx_put_q) credits_d = CRED_FULL;
        if ((credits_q != '0) && (req0_valid || req1_valid)) begin
          port_d     = pick;
          state_d    = pick ? GRANT1 : GRANT0;
          hold_cnt_d = '0;
        end
      end
      GRANT0, GRANT1: begin
        if (xfer) begin
          tx_put_d   = 1'b1;
          tx_data_d  = sel_data;
          credits_d  = credits_q - CW'(1);
          hold_cnt_d = '0;
          if (sel_last) begin
            state_d      = IDLE;
            last_grant_d = port_q;
          end else if (credits_q == CW'(1)) begin
            state_d       = DRAIN;
            drain_first_d = 1'b1;
          end
        end else if (HOLD_MAX != 0) begin
          if (hold_cnt_q == HOLD_LIM) begin
            state_d      = IDLE;
            abort_d      = 1'b1;
            last_grant_d = port_q;
            hold_cnt_d   = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HW'(1);
          end
        end
      end
      DRAIN: begin
        // The final put is still in flight on the first cycle, so tx_empty is stale there.
        drain_first_d = 1'b0;
        if (!drain_first_q && tx_empty) begin
          credits_d = CRED_FULL;
          state_d   = port_q ? GRANT1 : GRANT0;
        end
      end
      default: state_d = IDLE;
    endcase

    grant_d = (state_d == IDLE) ? 2'b00 : (port_d ? 2'b10 : 2'b01);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      port_q        <= 1'b0;
      last_grant_q  <= 1'b1;
      credits_q     <= CRED_FULL;
      hold_cnt_q    <= '0;
      drain_first_q <= 1'b0;
      tx_put_q      <= 1'b0;
      tx_data_q     <= 8'h00;
      abort_q       <= 1'b0;
      grant_q       <= 2'b00;
    end else begin
      state_q       <= state_d;
      port_q        <= port_d;
      last_grant_q  <= last_grant_d;
      credits_q     <= credits_d;
      hold_cnt_q    <= hold_cnt_d;
      drain_first_q <= drain_first_d;
      tx_put_q      <= tx_put_d;
      tx_data_q     <= tx_data_d;
      abort_q       <= abort_d;
      grant_q       <= grant_d;
    end
  end

  assign tx_put  = tx_put_q;
  assign tx_data = tx_data_q;
  assign abort   = abort_q;
  assign grant   = grant_q;

endmodule
